// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word and shifts it out MSB first.
// Define PISO_TX_PARITY_EN to append one even-parity bit after the data bits.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  input  logic [WIDTH-1:0] DATA,
  output logic             LOAD_READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             DONE
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_d, svalid_d, done_d, ready_d;
`ifdef PISO_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Outputs are computed for the next state and registered, so no input reaches an output combinationally.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    sout_d   = 1'b0;
    svalid_d = 1'b0;
    done_d   = 1'b0;
    ready_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (LOAD_VALID) begin
          state_d  = SHIFT;
          sr_d     = DATA;
          cnt_d    = '0;
          sout_d   = DATA[WIDTH-1];
          svalid_d = 1'b1;
`ifdef PISO_TX_PARITY_EN
          par_d    = ^DATA;
`endif
        end else begin
          ready_d = 1'b1;
        end
      end
      SHIFT: begin
        // Counter holds at LAST on exit rather than wrapping.
        if (cnt_q == LAST) begin
`ifdef PISO_TX_PARITY_EN
          state_d  = PAR;
          sout_d   = par_q;
          svalid_d = 1'b1;
`else
          state_d  = FIN;
          done_d   = 1'b1;
`endif
        end else begin
          cnt_d    = cnt_q + 1'b1;
          sr_d     = {sr_q[WIDTH-2:0], 1'b0};
          sout_d   = sr_q[WIDTH-2];
          svalid_d = 1'b1;
        end
      end
`ifdef PISO_TX_PARITY_EN
      PAR: begin
        state_d = FIN;
        done_d  = 1'b1;
      end
`endif
      FIN: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      LOAD_READY <= 1'b1;
      SOUT       <= 1'b0;
      SVALID     <= 1'b0;
      DONE       <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      LOAD_READY <= ready_d;
      SOUT       <= sout_d;
      SVALID     <= svalid_d;
      DONE       <= done_d;
`ifdef PISO_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, the number of data bits per word (legal range 2..32).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port LOAD_VALID, input, 1 bit, meaning the producer offers a word on DATA.
REQ-005 The block SHALL have port DATA, input, WIDTH bits, meaning the parallel word to serialise.
REQ-006 The block SHALL have port LOAD_READY, output, 1 bit, meaning the block can accept a word this cycle.
REQ-007 The block SHALL have port SOUT, output, 1 bit, meaning the serial data bit.
REQ-008 The block SHALL have port SVALID, output, 1 bit, meaning SOUT carries a valid bit this cycle.
REQ-009 The block SHALL have port DONE, output, 1 bit, a one-cycle pulse marking the end of a word.

Function
REQ-010 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-011 The FSM SHALL have states IDLE, SHIFT, PAR and FIN; PAR is reachable only with the Configuration feature enabled.
REQ-012 In IDLE: LOAD_READY=1, SVALID=0, SOUT=0, DONE=0.
REQ-013 Accept occurs at a rising edge with LOAD_VALID=1 and LOAD_READY=1: DATA captured into a WIDTH-bit shift register, bit counter cleared, IDLE->SHIFT, LOAD_READY dropped to 0 in the same edge.
REQ-014 In SHIFT, SOUT SHALL present the data bits MSB first, one per cycle, with SVALID=1; the first bit appears in the cycle following the accept edge.
REQ-015 The bit counter SHALL be ceil(log2(WIDTH)) bits wide, increment once per SHIFT cycle, and leave SHIFT after exactly WIDTH cycles with no wrap or overrun.
REQ-016 SHIFT SHALL go to PAR (feature enabled) or FIN (feature disabled) after the last data bit.
REQ-017 In FIN: DONE=1 for exactly one cycle with SVALID=0 and SOUT=0, then FIN->IDLE unconditionally.
REQ-018 LOAD_VALID and DATA SHALL be ignored outside IDLE; DATA changes during SHIFT SHALL NOT affect SOUT.
REQ-019 Word period SHALL be WIDTH+2 cycles from accept to next possible accept (WIDTH+3 with parity); LOAD_VALID held high gives back-to-back words at this rate.

Reset
REQ-020 RST=0 SHALL immediately, without a clock edge, force IDLE, shift register=0, counter=0, LOAD_READY=1, SOUT=0, SVALID=0, DONE=0.
REQ-021 Reset asserted mid-word SHALL abandon the word with no DONE pulse; the first rising edge after RST=1 behaves as in IDLE.

Configuration
REQ-022 Macro PISO_TX_PARITY_EN defined: after the last data bit, one PAR cycle SHALL drive SOUT = XOR of all WIDTH captured bits (even parity), SVALID=1, then PAR->FIN.
REQ-023 Macro PISO_TX_PARITY_EN undefined: the PAR state and parity logic SHALL be absent, and SHIFT SHALL go directly to FIN.

Verification
REQ-024 Reset then idle: RST=0 for 2 cycles, release -> LOAD_READY=1, SVALID=0, SOUT=0, DONE=0.
REQ-025 WIDTH=8, accept DATA=0xA5 -> SOUT 1,0,1,0,0,1,0,1 on 8 consecutive cycles with SVALID=1, then DONE=1 for one cycle, then LOAD_READY=1.
REQ-026 With PISO_TX_PARITY_EN: 0xA5 -> 9th SVALID bit 0; 0x07 -> 9th SVALID bit 1; DONE follows the 9th bit.
REQ-027 Accept 0xFF, then drive LOAD_VALID=1 with DATA=0x00 during SHIFT -> SOUT stays 1 for all 8 bits; 0x00 is accepted only after FIN.
REQ-028 Assert RST=0 mid-word after the 3rd bit of 0x3C -> outputs reach reset values without a clock edge and no DONE; next word 0x81 serialises as 1,0,0,0,0,0,0,1.
REQ-029 LOAD_VALID held high with 0x12 then 0x34 -> accepts spaced exactly 10 cycles apart (11 with parity), bit streams correct.
